// File: rtl/fdiv_period_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fdiv_period_meter_if
//  Description : Bundles the measurement-side signals of fdiv_period_meter.
//                The master side drives the enable and the tick stream.
//                The slave side (the meter) returns the measured period and
//                its status flags.
//
//  Signals     : en          - measurement enable            (master -> slave)
//                fdclk_in    - divided-clock tick stream     (master -> slave)
//                period      - last measured period, CW bits (slave  -> master)
//                period_vld  - one-cycle pulse on update     (slave  -> master)
//                locked      - division ratio stable         (slave  -> master)
//                err         - mismatch-after-lock / timeout (slave  -> master)
//
//  Parameters  : CW - period width; must match the meter's CW.
//
//  Revision    : 1.0 - initial release
// ============================================================================
interface fdiv_period_meter_if #(
    parameter int CW = 8
);
    logic          en;
    logic          fdclk_in;
    logic [CW-1:0] period;
    logic          period_vld;
    logic          locked;
    logic          err;

    modport master (
        output en,
        output fdclk_in,
        input  period,
        input  period_vld,
        input  locked,
        input  err
    );

    modport slave (
        input  en,
        input  fdclk_in,
        output period,
        output period_vld,
        output locked,
        output err
    );
endinterface

`default_nettype wire

// File: rtl/fdiv_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : fdiv_period_meter
//  Description : Period meter and lock detector for divided-clock tick
//                streams. The meter counts clk cycles between rising edges
//                of fdclk_in. It reports each measured period and asserts
//                locked after LOCK_CNT consecutive matching periods. It
//                pulses err on a mismatch while locked, or when no tick
//                arrives before the counter saturates.
//
//  Ports       : clk     - system clock; all logic runs on posedge
//                rst     - synchronous active-high reset
//                bus_io  - fdiv_period_meter_if.slave:
//                            en, fdclk_in        (inputs)
//                            period, period_vld,
//                            locked, err         (registered outputs)
//
//  Parameters  : CW       - period counter width; the largest measurable
//                           period is 2^CW-1
//                LOCK_CNT - consecutive matching periods needed for lock;
//                           must be at least 2
//
//  Build option: FDIV_PERIOD_METER_TOL_EN
//                  When defined, a period within +/-1 of the reference
//                  counts as a match, and the reference is left unchanged.
//                  When undefined, only an exact match counts.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fdiv_period_meter #(
    parameter int CW       = 8,
    parameter int LOCK_CNT = 3
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fdiv_period_meter_if.slave  bus_io
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The match counter only needs to reach LOCK_CNT (it saturates there).
    localparam int            MW       = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0] LOCK_M   = MW'(LOCK_CNT);
    localparam logic [MW-1:0] ONE_M    = MW'(1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // waiting for the first tick edge
        ST_ACQ    = 2'd1,   // measuring, collecting matching periods
        ST_LOCKED = 2'd2    // ratio stable
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    state_t         state_q,      state_d;
    logic           prev_q,       prev_d;
    logic [CW-1:0]  cnt_q,        cnt_d;
    logic [CW-1:0]  ref_q,        ref_d;
    logic [MW-1:0]  match_q,      match_d;
    logic [CW-1:0]  period_q,     period_d;
    logic           period_vld_q, period_vld_d;
    logic           locked_q,     locked_d;
    logic           err_q,        err_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic           w_edge;         // rising edge of the tick stream
    logic           w_cnt_sat;      // counter sits at its maximum
    logic           w_match;        // current count agrees with the reference
    logic [MW-1:0]  w_match_inc;    // match count + 1, held at LOCK_CNT
    logic [MW-1:0]  w_match_new;    // match count after this edge

    // prev_q resets to 1. A level that is already high when reset
    // releases therefore does not count as an edge.
    assign w_edge    = bus_io.fdclk_in & ~prev_q;
    assign w_cnt_sat = (cnt_q == CNT_MAX);

`ifdef FDIV_PERIOD_METER_TOL_EN
    // Absolute difference between count and reference. Taking the
    // difference in the right order avoids any wrap-around.
    logic [CW-1:0]  w_diff;

    assign w_diff  = (cnt_q >= ref_q) ? (cnt_q - ref_q) : (ref_q - cnt_q);
    assign w_match = (w_diff <= ONE_C);
`else
    assign w_match = (cnt_q == ref_q);
`endif

    // In LOCKED every further match would keep incrementing the counter.
    // Holding it at LOCK_CNT keeps it from wrapping on long locked runs.
    assign w_match_inc = (match_q == LOCK_M) ? match_q : (match_q + ONE_M);
    assign w_match_new = w_match ? w_match_inc : ONE_M;

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // Defaults: hold the state and the measurement. Pulses are low.
        // The free-running counter restarts at 1 on every edge and
        // saturates otherwise.
        state_d      = state_q;
        prev_d       = bus_io.fdclk_in;
        cnt_d        = w_edge    ? ONE_C   :
                       w_cnt_sat ? cnt_q   : (cnt_q + ONE_C);
        ref_d        = ref_q;
        match_d      = match_q;
        period_d     = period_q;
        period_vld_d = 1'b0;
        locked_d     = locked_q;
        err_d        = 1'b0;

        if (!bus_io.en) begin
            // Disabled: drop back to IDLE silently. period holds its value,
            // and prev keeps tracking the input through the default.
            state_d  = ST_IDLE;
            locked_d = 1'b0;
            match_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The first edge only starts the counter. There is no
                    // complete period to report yet.
                    if (w_edge) begin
                        state_d = ST_ACQ;
                    end
                end

                ST_ACQ: begin
                    if (w_edge) begin
                        period_d     = cnt_q;
                        period_vld_d = 1'b1;
                        match_d      = w_match_new;
                        // A tolerated near-match keeps the original
                        // reference, so the reference cannot drift.
                        if (!w_match) begin
                            ref_d = cnt_q;
                        end
                        if (w_match_new == LOCK_M) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else if (w_cnt_sat) begin
                        // No tick within the measurable range.
                        state_d  = ST_IDLE;
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        match_d  = '0;
                    end
                end

                ST_LOCKED: begin
                    if (w_edge) begin
                        period_d     = cnt_q;
                        period_vld_d = 1'b1;
                        if (w_match) begin
                            match_d = w_match_inc;
                        end else begin
                            // Ratio changed. The offending period becomes
                            // the new reference and counts as the first
                            // match of the next acquisition.
                            state_d  = ST_ACQ;
                            err_d    = 1'b1;
                            locked_d = 1'b0;
                            ref_d    = cnt_q;
                            match_d  = ONE_M;
                        end
                    end else if (w_cnt_sat) begin
                        state_d  = ST_IDLE;
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        match_d  = '0;
                    end
                end

                default: begin
                    state_d  = ST_IDLE;
                    locked_d = 1'b0;
                    match_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prev_q       <= 1'b1;
            cnt_q        <= '0;
            ref_q        <= '0;
            match_q      <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            ref_q        <= ref_d;
            match_q      <= match_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign bus_io.period     = period_q;
    assign bus_io.period_vld = period_vld_q;
    assign bus_io.locked     = locked_q;
    assign bus_io.err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fdiv_period_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fdiv_period_meter
//  Description : Directed self-checking bench for fdiv_period_meter.
//                Instance a uses CW=8. Instance b uses CW=4, so that its
//                timeout can be reached quickly. Both instances see the
//                same tick stream and the same reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fdiv_period_meter;

    logic clk = 1'b0;
    logic rst;
    logic en_r;
    logic fd_r;

    always #5 clk = ~clk;

    fdiv_period_meter_if #(.CW(8)) a_if ();
    fdiv_period_meter_if #(.CW(4)) b_if ();

    assign a_if.en       = en_r;
    assign a_if.fdclk_in = fd_r;
    assign b_if.en       = en_r;
    assign b_if.fdclk_in = fd_r;

    fdiv_period_meter #(.CW(8), .LOCK_CNT(3)) u_a (
        .clk    (clk),
        .rst    (rst),
        .bus_io (a_if.slave)
    );

    fdiv_period_meter #(.CW(4), .LOCK_CNT(3)) u_b (
        .clk    (clk),
        .rst    (rst),
        .bus_io (b_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse counters, sampled 2 time units after each rising clock edge.
    int a_vld_n = 0, a_err_n = 0, b_vld_n = 0, b_err_n = 0;
    always @(posedge clk) begin
        #2;
        if (a_if.period_vld === 1'b1) a_vld_n++;
        if (a_if.err        === 1'b1) a_err_n++;
        if (b_if.period_vld === 1'b1) b_vld_n++;
        if (b_if.err        === 1'b1) b_err_n++;
    end

    logic [7:0] sa_per;
    logic       sa_vld, sa_lck, sa_err;
    logic [3:0] sb_per;
    logic       sb_vld, sb_lck, sb_err;

    task automatic take_sample();
        sa_per = a_if.period; sa_vld = a_if.period_vld;
        sa_lck = a_if.locked; sa_err = a_if.err;
        sb_per = b_if.period; sb_vld = b_if.period_vld;
        sb_lck = b_if.locked; sb_err = b_if.err;
    endtask

    // One tick period of p cycles, with the tick high for h cycles. The
    // outputs are sampled one cycle after the rising edge, which is when
    // the meter reports the period that ended at that edge.
    task automatic period_cyc(input int p, input int h);
        @(negedge clk);
        fd_r = 1'b1;
        for (int i = 1; i < p; i++) begin
            @(negedge clk);
            if (i == 1) take_sample();
            fd_r = (i < h);
        end
    endtask

    task automatic chk_a(input string tag, input logic vld, input logic [7:0] per,
                         input logic lck, input logic err);
        check_value({tag, ".a.vld"}, 32'(sa_vld), 32'(vld));
        if (vld) check_value({tag, ".a.period"}, 32'(sa_per), 32'(per));
        check_value({tag, ".a.locked"}, 32'(sa_lck), 32'(lck));
        check_value({tag, ".a.err"}, 32'(sa_err), 32'(err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        en_r = 1'b1;
        fd_r = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int v0, e0;

    initial begin
        rst  = 1'b1;
        en_r = 1'b1;
        fd_r = 1'b0;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        take_sample();
        check_value("rst.a.period", 32'(sa_per), 0);
        check_value("rst.a.vld",    32'(sa_vld), 0);
        check_value("rst.a.locked", 32'(sa_lck), 0);
        check_value("rst.a.err",    32'(sa_err), 0);
        check_value("rst.b.period", 32'(sb_per), 0);
        rst = 1'b0;

        // ---------------- divide-by-5, then ratio change to 7 ----------------
        v0 = a_vld_n; e0 = a_err_n;
        period_cyc(5, 1);
        check_value("d5.first.vld", 32'(sa_vld), 0);
        period_cyc(5, 1); chk_a("d5.p2", 1, 5, 0, 0);
        period_cyc(5, 1); chk_a("d5.p3", 1, 5, 0, 0);
        period_cyc(7, 1); chk_a("d5.p4", 1, 5, 1, 0);
        check_value("d5.vld_count", 32'(a_vld_n - v0), 3);
        check_value("d5.err_count", 32'(a_err_n - e0), 0);
        period_cyc(7, 1); chk_a("p7.mis",  1, 7, 0, 1);
        period_cyc(7, 1); chk_a("p7.m2",   1, 7, 0, 0);
        period_cyc(7, 1); chk_a("p7.lock", 1, 7, 1, 0);

        // Dropping en clears lock without err or period_vld.
        @(negedge clk);
        en_r = 1'b0;
        @(negedge clk);
        take_sample();
        chk_a("en0", 0, 0, 0, 0);
        check_value("en0.period_hold", 32'(sa_per), 7);
        en_r = 1'b1;

        // ---------------- gated stream: high 2, low 8 ----------------
        do_reset();
        v0 = a_vld_n;
        period_cyc(10, 2);
        check_value("g10.first.vld", 32'(sa_vld), 0);
        period_cyc(10, 2); chk_a("g10.p2", 1, 10, 0, 0);
        period_cyc(10, 2); chk_a("g10.p3", 1, 10, 0, 0);
        period_cyc(10, 2); chk_a("g10.p4", 1, 10, 1, 0);
        check_value("g10.vld_count", 32'(a_vld_n - v0), 3);

        // ---------------- reset while locked with tick high ----------------
        @(negedge clk);
        rst  = 1'b1;
        fd_r = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        take_sample();
        chk_a("rstlk", 0, 0, 0, 0);
        check_value("rstlk.a.period", 32'(sa_per), 0);
        v0 = a_vld_n;
        repeat (5) @(negedge clk);
        fd_r = 1'b0;
        repeat (3) @(negedge clk);
        check_value("rstlk.held_high_vld", 32'(a_vld_n - v0), 0);
        period_cyc(5, 1);
        check_value("rstlk.edge1.vld", 32'(sa_vld), 0);
        period_cyc(5, 1); chk_a("rstlk.edge2", 1, 5, 0, 0);

        // ---------------- CW=4 timeout on instance b ----------------
        do_reset();
        e0 = b_err_n;
        repeat (4) period_cyc(5, 1);
        check_value("to.b.locked_before", 32'(sb_lck), 1);
        check_value("to.b.period_before", 32'(sb_per), 5);
        repeat (30) @(negedge clk);
        take_sample();
        check_value("to.b.locked_after", 32'(sb_lck), 0);
        check_value("to.b.err_count", 32'(b_err_n - e0), 1);
        period_cyc(5, 1);
        check_value("to.b.edge1.vld", 32'(sb_vld), 0);
        period_cyc(5, 1);
        check_value("to.b.edge2.vld", 32'(sb_vld), 1);
        check_value("to.b.edge2.period", 32'(sb_per), 5);

        // ---------------- alternating 5/6 periods ----------------
        do_reset();
        period_cyc(5, 1);
        period_cyc(6, 1);
        period_cyc(5, 1);
        check_value("tol.p2.period", 32'(sa_per), 6);
        period_cyc(6, 1);
        check_value("tol.p3.vld",    32'(sa_vld), 1);
        check_value("tol.p3.period", 32'(sa_per), 5);
`ifdef FDIV_PERIOD_METER_TOL_EN
        check_value("tol.p3.locked", 32'(sa_lck), 1);
`else
        check_value("tol.p3.locked", 32'(sa_lck), 0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
